// File: rtl/dii_package.sv
// DII debug interconnect flit type shared by trace and ring blocks.
package dii_package;

   typedef struct packed {
      logic        valid;
      logic        last;
      logic [15:0] data;
   } dii_flit;

endpackage

// File: rtl/osd_trace_arb_pkg.sv
// Shared types and round-robin search helper for osd_trace_arbiter.
package osd_trace_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

   localparam int unsigned MAX_SRC  = 32;
   localparam int unsigned RR_IDX_W = 6;

   typedef logic [RR_IDX_W-1:0] rr_idx_t;

   typedef struct packed {
      logic    found;
      rr_idx_t idx;
   } rr_sel_t;

   // First set bit of req[n-1:0], scanning start, start+1, ... modulo n.
   function automatic rr_sel_t rr_search(
      input logic [MAX_SRC-1:0] req,
      input rr_idx_t            n,
      input rr_idx_t            start
   );
      rr_sel_t r;
      rr_idx_t i;
      r = '0;
      for (int k = 0; k < MAX_SRC; k++) begin
         i = start + rr_idx_t'(k);
         if (i >= n) i = i - n;
         if (rr_idx_t'(k) < n && !r.found &&
             (req & (MAX_SRC'(1) << i)) != '0) begin
            r.found = 1'b1;
            r.idx   = i;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/osd_dii_skid_buf.sv
// Two-entry DII skid buffer: registered output, full throughput,
// no combinational path from out_ready to in_ready.
module osd_dii_skid_buf
   import dii_package::*;
(
   input  logic    clk,
   input  logic    rst,
   input  dii_flit in_flit,
   output logic    in_ready,
   output dii_flit out_flit,
   input  logic    out_ready
);

   dii_flit main_q, main_d;
   dii_flit skid_q, skid_d;

   assign in_ready = !skid_q.valid;
   assign out_flit = main_q;

   // skid only holds data while main is stalled and full
   always_comb begin
      main_d = main_q;
      skid_d = skid_q;
      if (skid_q.valid) begin
         if (out_ready) begin
            main_d       = skid_q;
            skid_d.valid = 1'b0;
         end
      end else if (!main_q.valid || out_ready) begin
         main_d = in_flit;
      end else if (in_flit.valid) begin
         skid_d = in_flit;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         main_q <= main_d;
         skid_q <= skid_d;
      end
   end

endmodule

// File: rtl/osd_trace_arbiter.sv
// Packet-locked round-robin merge of NUM_SRC DII trace streams.
// Define OSD_TRACE_ARB_OUTREG_EN to register debug_out via osd_dii_skid_buf.
module osd_trace_arbiter
   import dii_package::*;
   import osd_trace_arb_pkg::*;
#(
   parameter  int unsigned NUM_SRC = 2,
   localparam int unsigned IDX_W   = $clog2(NUM_SRC)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic    [NUM_SRC-1:0]  src_en,
   input  dii_flit [NUM_SRC-1:0]  debug_in,
   output logic    [NUM_SRC-1:0]  debug_in_ready,
   output dii_flit                debug_out,
   input  logic                   debug_out_ready,
   output logic    [IDX_W-1:0]    cur_src,
   output logic                   busy
);

   localparam int unsigned PAD_W = RR_IDX_W - IDX_W;

   arb_state_t         state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
   logic [IDX_W-1:0]   sel;
   logic [PAD_W-1:0]   sel_unused;
   logic [NUM_SRC-1:0] req;
   rr_sel_t            rr;
   dii_flit            arb_flit;
   logic               arb_ready;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
      return (x == IDX_W'(NUM_SRC - 1)) ? '0 : x + IDX_W'(1);
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         req[i] = debug_in[i].valid & src_en[i];
      end
   end

   always_comb begin
      rr = rr_search(MAX_SRC'(req), RR_IDX_W'(NUM_SRC), RR_IDX_W'(rr_ptr_q));
      {sel_unused, sel} = rr.idx;
   end

   // arbitration is suppressed while reset is held
   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      lock_idx_d     = lock_idx_q;
      arb_flit       = '0;
      debug_in_ready = '0;
      if (rst) begin
         unique case (state_q)
            ARB_IDLE: begin
               if (rr.found) begin
                  arb_flit            = debug_in[sel];
                  debug_in_ready[sel] = arb_ready;
                  if (arb_ready && debug_in[sel].last) begin
                     rr_ptr_d = wrap_inc(sel);
                  end else begin
                     lock_idx_d = sel;
                     state_d    = ARB_LOCKED;
                  end
               end
            end
            ARB_LOCKED: begin
               arb_flit                   = debug_in[lock_idx_q];
               debug_in_ready[lock_idx_q] = arb_ready;
               if (arb_flit.valid && arb_ready && arb_flit.last) begin
                  state_d  = ARB_IDLE;
                  rr_ptr_d = wrap_inc(lock_idx_q);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ARB_IDLE;
         rr_ptr_q   <= '0;
         lock_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_idx_q <= lock_idx_d;
      end
   end

   assign busy    = (state_q == ARB_LOCKED);
   assign cur_src = !rst ? '0 : (busy ? lock_idx_q : sel);

`ifdef OSD_TRACE_ARB_OUTREG_EN
   osd_dii_skid_buf u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_flit   (arb_flit),
      .in_ready  (arb_ready),
      .out_flit  (debug_out),
      .out_ready (debug_out_ready)
   );
`else
   assign debug_out = arb_flit;
   assign arb_ready = debug_out_ready;
`endif

endmodule

// File: tb/tb_osd_trace_arbiter.sv
// Randomized scoreboard bench for osd_trace_arbiter (NUM_SRC=4),
// valid with or without OSD_TRACE_ARB_OUTREG_EN.
module tb_osd_trace_arbiter;
   import dii_package::*;

   localparam int N = 4;

   typedef struct {
      logic        last;
      logic [15:0] data;
   } flit_t;

   typedef struct {
      int          src;
      logic        last;
      logic [15:0] data;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic    [N-1:0]   src_en;
   dii_flit [N-1:0]   din;
   logic    [N-1:0]   din_ready;
   dii_flit           dout;
   logic              dout_ready;
   logic    [1:0]     cur_src;
   logic              busy;

   int     checks = 0;
   int     errors = 0;
   flit_t  srcq [N][$];
   exp_t   expq [$];
   int     mptr = 0;
   int     rdy_mode = 0;
   bit     gaps = 0;
   int     ndone;

   always #5 clk = ~clk;

   osd_trace_arbiter #(.NUM_SRC(N)) dut (
      .clk             (clk),
      .rst             (rst),
      .src_en          (src_en),
      .debug_in        (din),
      .debug_in_ready  (din_ready),
      .debug_out       (dout),
      .debug_out_ready (dout_ready),
      .cur_src         (cur_src),
      .busy            (busy)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // reference model: packet-level stream per source plus expected order
   task automatic add_flit(input int s, input logic last, input logic [15:0] d);
      flit_t f;
      exp_t  e;
      f.last = last;
      f.data = d;
      e.src  = s;
      e.last = last;
      e.data = d;
      srcq[s].push_back(f);
      expq.push_back(e);
   endtask

   task automatic gen_pkt(input int s, input int len);
      for (int j = 0; j < len; j++) add_flit(s, j == len - 1, 16'($urandom));
      mptr = (s + 1) % N;
   endtask

   // all listed sources backlogged: grants rotate from mptr over those with work left
   task automatic gen_phase(input logic [N-1:0] mask, input int npk,
                            input int lmin, input int lmax);
      int rem [N];
      int left;
      int s;
      left = 0;
      for (int i = 0; i < N; i++) begin
         rem[i] = mask[i] ? npk : 0;
         left += rem[i];
      end
      while (left > 0) begin
         s = mptr;
         while (rem[s] == 0) s = (s + 1) % N;
         gen_pkt(s, int'($urandom_range(lmax, lmin)));
         rem[s]--;
         left--;
      end
   endtask

   task automatic lock_chk(input int i);
      chk($sformatf("busy_mid_pkt_s%0d", i), 32'(busy), 32'd1);
      chk($sformatf("cur_src_mid_pkt_s%0d", i), 32'(cur_src), 32'(i));
   endtask

   task automatic drive_src(input int i);
      bit    mid;
      bit    fire;
      int    cyc;
      flit_t f;
      mid = 0;
      cyc = 0;
      while (srcq[i].size() > 0) begin
         f = srcq[i][0];
         din[i] = {1'b1, f.last, f.data};
         @(negedge clk);
         fire = din_ready[i] && din[i].valid;
         if (mid) lock_chk(i);
         @(posedge clk);
         #1;
         cyc++;
         if (fire) begin
            void'(srcq[i].pop_front());
            mid = !f.last;
            if (mid && gaps && $urandom_range(3, 0) == 0) begin
               din[i].valid = 1'b0;
               repeat ($urandom_range(3, 1)) begin
                  @(negedge clk);
                  lock_chk(i);
                  @(posedge clk);
                  #1;
               end
            end
         end
         if (cyc > 4000) begin
            chk($sformatf("src%0d_stalled_flits", i), 32'(srcq[i].size()), 32'd0);
            srcq[i].delete();
         end
      end
      din[i].valid = 1'b0;
      ndone++;
   endtask

   task automatic run_phase();
      @(posedge clk);
      #1;
      ndone = 0;
      for (int i = 0; i < N; i++) begin
         automatic int k = i;
         fork
            drive_src(k);
         join_none
      end
      for (int c = 0; c < 6000 && ndone < N; c++) @(posedge clk);
      for (int c = 0; c < 300 && expq.size() > 0; c++) @(posedge clk);
      chk("undelivered_flits", 32'(expq.size()), 32'd0);
      expq.delete();
   endtask

   task automatic monitor();
      bit      hold;
      dii_flit prev;
      exp_t    e;
      hold = 0;
      prev = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            hold = 0;
         end else begin
            chk("ready_onehot", 32'($countones(din_ready) <= 1), 32'd1);
            if (hold) begin
               chk("stall_valid_held", 32'(dout.valid), 32'd1);
               chk("stall_flit_held", 32'({dout.last, dout.data}),
                   32'({prev.last, prev.data}));
            end
            if (dout.valid && dout_ready) begin
               if (expq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL extra_flit: got %0h expected none", dout.data);
               end else begin
                  e = expq.pop_front();
                  chk($sformatf("data_s%0d", e.src), 32'(dout.data), 32'(e.data));
                  chk($sformatf("last_s%0d", e.src), 32'(dout.last), 32'(e.last));
               end
            end
            hold = dout.valid && !dout_ready;
            prev = dout;
         end
      end
   endtask

   task automatic drive_ready();
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = ($urandom_range(2, 0) != 0);
            default: dout_ready = ~dout_ready;
         endcase
      end
   endtask

   task automatic en_watch();
      int c;
      c = 0;
      while (c < 50 && !(busy && cur_src == 2'd1)) begin
         @(posedge clk);
         #2;
         c++;
      end
      chk("src1_locked", 32'(busy && cur_src == 2'd1), 32'd1);
      src_en = 4'b1101;
      c = 0;
      while (c < 3000 && expq.size() > 3) begin
         @(posedge clk);
         #2;
         if (!(busy && cur_src == 2'd1))
            chk("disabled_src1_ready", 32'(din_ready[1]), 32'd0);
         c++;
      end
      src_en = 4'b1111;
   endtask

   initial begin
      rst        = 1'b0;
      din        = '0;
      src_en     = 4'b1111;
      dout_ready = 1'b1;
      fork
         monitor();
         drive_ready();
      join_none

      #1;
      chk("rst_out_valid", 32'(dout.valid), 32'd0);
      chk("rst_in_ready", 32'(din_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cur_src", 32'(cur_src), 32'd0);
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("idle_out_valid", 32'(dout.valid), 32'd0);
         chk("idle_in_ready", 32'(din_ready), 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
      end

      add_flit(1, 1'b0, 16'h0000);
      add_flit(1, 1'b0, 16'h8005);
      add_flit(1, 1'b1, 16'h1234);
      mptr = 2;
      run_phase();

      gen_phase(4'b1111, 3, 2, 2);
      run_phase();

      rdy_mode = 2;
      gaps     = 1;
      gen_pkt(2, 5);
      gen_pkt(0, 2);
      run_phase();

      rdy_mode = 0;
      gaps     = 0;
      gen_pkt(1, 5);
      repeat (2) begin
         gen_pkt(2, 2);
         gen_pkt(3, 2);
         gen_pkt(0, 2);
      end
      gen_pkt(1, 3);
      fork
         en_watch();
      join_none
      run_phase();

      rdy_mode = 1;
      gaps     = 1;
      repeat (6) begin
         gen_phase(4'($urandom_range(15, 1)), int'($urandom_range(3, 1)), 1, 4);
         run_phase();
      end

      rdy_mode = 0;
      gaps     = 0;
      repeat (2) @(posedge clk);
      #2;
      din[3] = {1'b1, 1'b0, 16'hA001};
      expq.push_back('{3, 1'b0, 16'hA001});
      @(posedge clk);
      #2;
      din[3] = {1'b1, 1'b0, 16'hA002};
      expq.push_back('{3, 1'b0, 16'hA002});
      @(posedge clk);
      #2;
      din[3] = {1'b1, 1'b0, 16'hA003};
      #2 rst = 1'b0;
      #1;
      chk("midpkt_rst_out_valid", 32'(dout.valid), 32'd0);
      chk("midpkt_rst_in_ready", 32'(din_ready), 32'd0);
      chk("midpkt_rst_busy", 32'(busy), 32'd0);
      chk("midpkt_rst_cur_src", 32'(cur_src), 32'd0);
      expq.delete();
      din = '0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      mptr = 0;
      gen_pkt(0, 1);
      gen_pkt(3, 1);
      run_phase();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
